// File: rtl/led_ctrl.sv
// led_ctrl: board-side sequencer between raw switches and the switch-to-LED
// datapath. The switch byte is synchronized, debounced, driven into the
// datapath, allowed to settle, and the datapath result is then captured onto
// the board LEDs. A walking-one test pattern can be selected with mode.
//
// Ports
//   clk       : single clock, rising edge
//   rst_n     : asynchronous active-low reset
//   swt[7:0]  : raw board switches (asynchronous to clk)
//   mode      : 1 selects the walking-one test pattern
//   core_led  : combinational datapath result for core_swt
//   core_swt  : registered switch value driven into the datapath
//   led       : registered board LED value
//   upd       : high for the single cycle in which led loads core_led
//   busy      : high while an update sequence is in progress
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for a new debounced switch value, forced update or mode
// APPLY   | drive stable_swt into the datapath, clear the force flag
// SETTLE  | let the datapath output settle (SETTLE_CYCLES cycles)
// CAPTURE | load led from core_led, pulse upd
// WALK    | walking-one test pattern on led

module led_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned SETTLE_CYCLES   = 2,
    parameter int unsigned WALK_DIV        = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] swt,
    input  logic       mode,
    input  logic [7:0] core_led,
    output logic [7:0] core_swt,
    output logic [7:0] led,
    output logic       upd,
    output logic       busy
);

    localparam logic [7:0] DEB_TC    = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0] SETTLE_TC = 4'(SETTLE_CYCLES - 1);
    localparam logic [7:0] WALK_TC   = 8'(WALK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_SETTLE,
        S_CAPTURE,
        S_WALK
    } state_t;

    state_t     state;
    state_t     state_nxt;

    logic [7:0] sync_1;
    logic [7:0] sync_2;
    logic [7:0] deb_cnt;
    logic [7:0] stable_swt;
    logic [3:0] settle_cnt;
    logic [7:0] walk_cnt;
    logic       force_upd;

    // sync_1 holds the value sync_2 takes on the next edge, so a mismatch
    // marks the edge on which the synchronized byte changes. deb_cnt then
    // counts how long sync_2 has held its current value; at the terminal
    // count sync_2 has been unchanged for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1     <= 8'h00;
            sync_2     <= 8'h00;
            deb_cnt    <= 8'h00;
            stable_swt <= 8'h00;
        end else begin
            sync_1 <= swt;
            sync_2 <= sync_1;
            if (sync_1 != sync_2) begin
                deb_cnt <= 8'h00;
            end else if (deb_cnt != DEB_TC) begin
                deb_cnt <= deb_cnt + 8'd1;
            end
            if (deb_cnt == DEB_TC) begin
                stable_swt <= sync_2;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        upd       = 1'b0;
        busy      = 1'b0;
        case (state)
            S_IDLE: begin
                if (mode) begin
                    state_nxt = S_WALK;
                end else if ((stable_swt != core_swt) || force_upd) begin
                    state_nxt = S_APPLY;
                end
            end
            S_APPLY: begin
                busy      = 1'b1;
                state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                busy = 1'b1;
                if (settle_cnt == 4'd0) begin
                    state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                busy      = 1'b1;
                upd       = 1'b1;
                state_nxt = S_IDLE;
            end
            S_WALK: begin
                if (!mode) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Force flag starts set so the LEDs are refreshed once after reset, and
    // is set again on leaving WALK so the test pattern is always replaced by
    // the datapath result even when the switches did not move.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_swt   <= 8'h00;
            led        <= 8'h00;
            force_upd  <= 1'b1;
            settle_cnt <= 4'd0;
            walk_cnt   <= 8'h00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (mode) begin
                        led      <= 8'h01;
                        walk_cnt <= WALK_TC;
                    end
                end
                S_APPLY: begin
                    core_swt   <= stable_swt;
                    force_upd  <= 1'b0;
                    settle_cnt <= SETTLE_TC;
                end
                S_SETTLE: begin
                    if (settle_cnt != 4'd0) begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                S_CAPTURE: begin
                    led <= core_led;
                end
                S_WALK: begin
                    if (!mode) begin
                        force_upd <= 1'b1;
                    end else if (walk_cnt == 8'h00) begin
                        led      <= {led[6:0], led[7]};
                        walk_cnt <= WALK_TC;
                    end else begin
                        walk_cnt <= walk_cnt - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_led_ctrl.sv
// Bench for led_ctrl: behavioural reference model checked every cycle, plus
// directed scenarios with hand-computed literal expectations and a
// randomized stimulus phase.
module tb_led_ctrl;

    localparam int DEB    = 16;
    localparam int SETTLE = 2;
    localparam int WDIV   = 8;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] swt   = 8'h00;
    logic       mode  = 1'b0;
    logic [7:0] core_led;
    logic [7:0] core_swt;
    logic [7:0] led;
    logic       upd;
    logic       busy;

    int vectors     = 0;
    int miscompares = 0;
    int prints      = 0;

    always #5 clk = ~clk;

    // Tutorial switch-to-LED datapath.
    function automatic logic [7:0] dp(input logic [7:0] s);
        return {s[7:4], s[3] & s[2], s[2] | s[1], s[1] & ~s[0], ~s[0]};
    endfunction

    assign core_led = dp(core_swt);

    led_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .SETTLE_CYCLES  (SETTLE),
        .WALK_DIV       (WDIV)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .swt     (swt),
        .mode    (mode),
        .core_led(core_led),
        .core_swt(core_swt),
        .led     (led),
        .upd     (upd),
        .busy    (busy)
    );

    // ---------------- reference model ----------------
    // m_pos: 0 = idle, 1 = apply, 2..SETTLE+1 = settling, SETTLE+2 = capture.
    // Walk pattern derived from cycles spent walking.
    logic [7:0] m_s1 = 8'h00, m_s2 = 8'h00, m_stable = 8'h00;
    logic [7:0] m_core = 8'h00, m_led = 8'h00, nstable;
    logic       m_force = 1'b1, m_walk = 1'b0, all_eq;
    int         m_pos = 0, m_age = 0;
    logic [7:0] hist[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 = 8'h00; m_s2 = 8'h00; m_stable = 8'h00;
            m_core = 8'h00; m_led = 8'h00; m_force = 1'b1;
            m_walk = 1'b0; m_pos = 0; m_age = 0;
            hist.delete();
        end else begin
            // accepted once the last DEB observations of the synced byte agree
            hist.push_back(m_s2);
            if (hist.size() > DEB) void'(hist.pop_front());
            all_eq = (hist.size() == DEB);
            for (int i = 0; i < hist.size(); i++)
                if (hist[i] != hist[0]) all_eq = 1'b0;
            nstable = all_eq ? m_s2 : m_stable;

            if (m_pos == SETTLE + 2) begin
                m_led = dp(m_core);
                m_pos = 0;
            end else if (m_pos > 0) begin
                if (m_pos == 1) begin
                    m_core  = m_stable;
                    m_force = 1'b0;
                end
                m_pos++;
            end else if (m_walk) begin
                if (!mode) begin
                    m_walk  = 1'b0;
                    m_force = 1'b1;
                end else begin
                    m_age++;
                    m_led = 8'h01 << ((m_age / WDIV) % 8);
                end
            end else if (mode) begin
                m_walk = 1'b1;
                m_age  = 0;
                m_led  = 8'h01;
            end else if ((m_stable != m_core) || m_force) begin
                m_pos = 1;
            end

            m_s2     = m_s1;
            m_s1     = swt;
            m_stable = nstable;
        end
    end

    always @(negedge clk) begin
        vectors++;
        if (led !== m_led || upd !== (m_pos == SETTLE + 2) ||
            busy !== (m_pos != 0) || core_swt !== m_core) begin
            miscompares++;
            if (prints < 40)
                $display("FAIL model_cmp t=%0t led got %h want %h, upd got %b want %b, busy got %b want %b, core_swt got %h want %h",
                         $time, led, m_led, upd, (m_pos == SETTLE + 2),
                         busy, (m_pos != 0), core_swt, m_core);
            prints++;
        end
    end

    // ---------------- helpers ----------------
    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        vectors++;
        if (act < lo || act > hi) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    // Watch n cycles: first upd cycle index (-1 if none), busy cycles, upd cycles.
    task automatic observe(input int n, output int first, output int bcnt, output int ucnt);
        first = -1; bcnt = 0; ucnt = 0;
        for (int i = 1; i <= n; i++) begin
            @(posedge clk); #1;
            if (busy) bcnt++;
            if (upd) begin
                ucnt++;
                if (first < 0) first = i;
            end
        end
    endtask

    task automatic wait_busy(input string name);
        int k;
        k = 0;
        while (!busy && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        check_range(name, k, 1, 39);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int         first, bcnt, ucnt, acc, r, hold;
        logic [7:0] e;
        logic [7:0] u_led[0:3];
        logic [7:0] u_core[0:3];
        logic       pu;

        step(3);
        check8("rst_led", led, 8'h00);
        check8("rst_core_swt", core_swt, 8'h00);
        check8("rst_upd", {7'd0, upd}, 8'h00);
        check8("rst_busy", {7'd0, busy}, 8'h00);

        // reset release: forced update of the datapath value for 0x00
        rst_n = 1'b1;
        observe(25, first, bcnt, ucnt);
        check_range("rst_upd_cnt", ucnt, 1, 1);
        check8("rst_led_after", led, 8'h01);
        check8("rst_core_after", core_swt, 8'h00);

        // 0x00 -> 0x02
        step(5);
        swt = 8'h02;
        observe(40, first, bcnt, ucnt);
        check_range("lat_02", first, 21, 23);
        check_range("busy_len_02", bcnt, 4, 4);
        check_range("upd_cnt_02", ucnt, 1, 1);
        check8("led_02", led, 8'h07);
        check8("core_02", core_swt, 8'h02);

        // 0xFF, then bounce swt[1] every 5 cycles
        swt = 8'hFF;
        observe(40, first, bcnt, ucnt);
        check_range("lat_ff", first, 21, 23);
        check8("led_ff", led, 8'hFC);
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            swt = swt ^ 8'h02;
            observe(5, first, bcnt, ucnt);
            acc += ucnt;
        end
        observe(40, first, bcnt, ucnt);
        acc += ucnt;
        check_range("bounce_upd_cnt", acc, 0, 0);
        check8("bounce_led", led, 8'hFC);
        check8("bounce_core", core_swt, 8'hFF);

        // walking one
        mode = 1'b1;
        @(posedge clk); #1;
        check8("walk_0", led, 8'h01);
        e = 8'h01;
        for (int k = 1; k <= 8; k++) begin
            repeat (WDIV) @(posedge clk);
            #1;
            e = {e[6:0], e[7]};
            check8($sformatf("walk_%0d", k), led, e);
        end
        mode = 1'b0;
        observe(30, first, bcnt, ucnt);
        check_range("walk_exit_upd_cnt", ucnt, 1, 1);
        check8("walk_exit_led", led, 8'hFC);
        check8("walk_exit_core", core_swt, 8'hFF);

        // 0xFF -> 0x00, then 0x0C arrives during SETTLE
        swt = 8'h00;
        wait_busy("wait_busy_00");
        @(posedge clk); #1;
        swt = 8'h0C;
        ucnt = 0; pu = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (pu && ucnt < 4) begin
                u_led[ucnt]  = led;
                u_core[ucnt] = core_swt;
                ucnt++;
            end
            pu = upd;
        end
        check_range("settle_chg_upd_cnt", ucnt, 2, 2);
        check8("settle_chg_led0", u_led[0], 8'h01);
        check8("settle_chg_core0", u_core[0], 8'h00);
        check8("settle_chg_led1", u_led[1], 8'h0D);
        check8("settle_chg_core1", u_core[1], 8'h0C);

        // reset during SETTLE
        swt = 8'h02;
        wait_busy("wait_busy_rst");
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check8("midrst_led", led, 8'h00);
        check8("midrst_upd", {7'd0, upd}, 8'h00);
        check8("midrst_busy", {7'd0, busy}, 8'h00);
        check8("midrst_core", core_swt, 8'h00);
        swt = 8'h00;
        step(3);
        rst_n = 1'b1;
        observe(25, first, bcnt, ucnt);
        check_range("midrst_upd_cnt", ucnt, 1, 1);
        check8("midrst_led_after", led, 8'h01);

        // randomized phase, checked by the model
        for (int it = 0; it < 300; it++) begin
            r = $urandom_range(0, 99);
            if (r < 55) begin
                swt  = 8'($urandom);
                hold = $urandom_range(1, 40);
            end else if (r < 72) begin
                swt  = swt ^ (8'h01 << $urandom_range(0, 7));
                hold = $urandom_range(1, 6);
            end else if (r < 90) begin
                mode = ~mode;
                hold = $urandom_range(1, 60);
            end else if (r < 95) begin
                rst_n = 1'b0;
                step($urandom_range(1, 3));
                rst_n = 1'b1;
                hold  = $urandom_range(1, 30);
            end else begin
                hold = 80;
            end
            step(hold);
        end
        mode = 1'b0;
        step(60);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
